mem_stage_sram: RTL and testbench

Parametrised memory pipeline stage for the five-stage core. It sits between the EXE and WB pipeline registers and maps ALU byte addresses onto an off-chip asynchronous SRAM narrower than the CPU word. Each load or store runs as a multi-beat, wait-stated sequence, and `freeze` stalls the pipeline until the sequence finishes. Pipeline control and data fields pass through combinationally, so the stage drops in where the single-width SRAM stage sits today.

---
 rtl/mem_stage_sram.sv | 180 ++++++++++++++++++
 tb/tb_mem_stage_sram.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram.sv
// EXE->WB memory stage over a narrow async SRAM: each miss runs BEATS*(WAIT_STATES+1) stalled cycles, then one DONE cycle.
// Define MEM_RD_CACHE_EN to compile in a one-entry read buffer that answers repeat reads without stalling.
module mem_stage_sram #(
  parameter int WORD_W      = 32,
  parameter int DQ_W        = 16,
  parameter int ADDR_W      = 18,
  parameter int WAIT_STATES = 1,
  parameter int BASE_ADDR   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pcIn,
  input  logic [31:0]       ALU_result,
  input  logic              wb_en,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [4:0]        dest,
  input  logic [WORD_W-1:0] reg2,
  inout  wire  [DQ_W-1:0]   SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_WE_N,
  output logic [31:0]       pcOut,
  output logic [31:0]       ALU_result_out,
  output logic              wb_en_out,
  output logic              mem_read_out,
  output logic [4:0]        dest_out,
  output logic [WORD_W-1:0] mem_result,
  output logic              freeze
);
  localparam int BEATS = WORD_W / DQ_W;
  localparam int BPW   = WORD_W / 8;
  localparam int SHIFT = $clog2(BPW);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [2:0]    LAST_WAIT = 3'(WAIT_STATES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [2:0]        wait_q, wait_d;
  logic [WORD_W-1:0] rbuf_q, rbuf_d;
  logic [WORD_W-1:0] res_q, res_d;

  logic [31:0]       widx;
  logic              req, rd_op, hit, active, last_cyc, last_beat, finish;
  logic [BW-1:0]     cur_beat;
  logic [2:0]        cur_wait;
  logic [DQ_W-1:0]   wr_beat;
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] hit_dat;

  assign widx  = (ALU_result - 32'(BASE_ADDR)) >> SHIFT;
  assign req   = mem_read | mem_write;
  assign rd_op = mem_read & ~mem_write;

  // The request cycle in IDLE already acts as beat 0 / wait 0, so the stall is exactly BEATS*(WAIT_STATES+1).
  assign active    = rst & ((state_q == S_ACCESS) | ((state_q == S_IDLE) & req & ~hit));
  assign cur_beat  = (state_q == S_ACCESS) ? beat_q : '0;
  assign cur_wait  = (state_q == S_ACCESS) ? wait_q : '0;
  assign last_cyc  = (cur_wait == LAST_WAIT);
  assign last_beat = (cur_beat == LAST_BEAT);
  assign finish    = active & last_cyc & last_beat;

  always_comb begin
    wr_beat = '0;
    rd_word = rbuf_q;
    for (int k = 0; k < BEATS; k++) begin
      if (cur_beat == BW'(k)) begin
        wr_beat                 = reg2[k*DQ_W +: DQ_W];
        rd_word[k*DQ_W +: DQ_W] = SRAM_DQ;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    rbuf_d  = rbuf_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE, S_ACCESS: begin
        if (active) begin
          if (last_cyc) begin
            if (rd_op) rbuf_d = rd_word;
            wait_d = '0;
            if (last_beat) begin
              state_d = S_DONE;
              beat_d  = '0;
              if (rd_op) res_d = rd_word;
            end else begin
              state_d = S_ACCESS;
              beat_d  = cur_beat + 1'b1;
            end
          end else begin
            state_d = S_ACCESS;
            beat_d  = cur_beat;
            wait_d  = cur_wait + 3'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A buffer hit also becomes the held result once the request moves on.
    if (hit) res_d = hit_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      wait_q  <= '0;
      rbuf_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      rbuf_q  <= rbuf_d;
      res_q   <= res_d;
    end
  end

`ifdef MEM_RD_CACHE_EN
  logic              c_vld_q, c_vld_d;
  logic [31:0]       c_tag_q, c_tag_d;
  logic [WORD_W-1:0] c_dat_q, c_dat_d;

  assign hit     = rst & (state_q == S_IDLE) & rd_op & c_vld_q & (c_tag_q == widx);
  assign hit_dat = c_dat_q;

  // Reads fill the buffer; writes to the buffered word keep it coherent.
  always_comb begin
    c_vld_d = c_vld_q;
    c_tag_d = c_tag_q;
    c_dat_d = c_dat_q;
    if (finish & rd_op) begin
      c_vld_d = 1'b1;
      c_tag_d = widx;
      c_dat_d = rd_word;
    end else if (finish & mem_write & c_vld_q & (c_tag_q == widx)) begin
      c_dat_d = reg2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_vld_q <= 1'b0;
      c_tag_q <= '0;
      c_dat_q <= '0;
    end else begin
      c_vld_q <= c_vld_d;
      c_tag_q <= c_tag_d;
      c_dat_q <= c_dat_d;
    end
  end

  assign mem_result = hit ? c_dat_q : res_q;
`else
  assign hit        = 1'b0;
  assign hit_dat    = '0;
  assign mem_result = res_q;
`endif

  assign freeze    = rst & req & ~hit & (state_q != S_DONE);
  // WE_N rises on the final cycle of each beat so address and data stay held across the strobe edge.
  assign SRAM_WE_N = ~(active & mem_write & ~last_cyc);
  assign SRAM_ADDR = active ? ADDR_W'(widx * 32'(BEATS) + 32'(cur_beat)) : '0;
  assign SRAM_DQ   = (active & mem_write) ? wr_beat : {DQ_W{1'bz}};

  assign pcOut          = pcIn;
  assign ALU_result_out = ALU_result;
  assign wb_en_out      = wb_en;
  assign mem_read_out   = mem_read;
  assign dest_out       = dest;
endmodule

// File: tb/tb_mem_stage_sram.sv
// Bench for mem_stage_sram: a reference model pushes per-cycle expectations that the captured bus activity is checked against.
module tb_mem_stage_sram;
  localparam int WS    = 1;
  localparam int BEATS = 2;
  localparam int NCYC  = BEATS * (WS + 1);
`ifdef MEM_RD_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  typedef struct packed {
    logic        frz;
    logic        we_n;
    logic [17:0] addr;
    logic [15:0] dq;
    logic [31:0] res;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcIn, ALU_result, reg2;
  logic        wb_en, mem_read, mem_write;
  logic [4:0]  dest;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  logic [31:0] pcOut, ALU_result_out, mem_result;
  logic        wb_en_out, mem_read_out, freeze;
  logic [4:0]  dest_out;

  logic        tb_drv;
  logic [15:0] sram    [0:255];
  logic [15:0] ref_mem [0:255];
  obs_t        exp_q[$];
  obs_t        obs_q[$];
  logic [31:0] exp_res;
  logic        c_vld;
  logic [31:0] c_tag, c_dat;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mem_stage_sram dut (
    .clk(clk), .rst(rst), .pcIn(pcIn), .ALU_result(ALU_result), .wb_en(wb_en),
    .mem_read(mem_read), .mem_write(mem_write), .dest(dest), .reg2(reg2),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
    .pcOut(pcOut), .ALU_result_out(ALU_result_out), .wb_en_out(wb_en_out),
    .mem_read_out(mem_read_out), .dest_out(dest_out), .mem_result(mem_result),
    .freeze(freeze)
  );

  // Released bus reads all ones; the SRAM model drives only on read sample cycles.
  pullup (SRAM_DQ);
  assign SRAM_DQ = tb_drv ? sram[SRAM_ADDR[7:0]] : 16'bz;
  always @(negedge clk) if (SRAM_WE_N === 1'b0) sram[SRAM_ADDR[7:0]] <= SRAM_DQ;

  task automatic expect_access(input logic rd, input logic wr, input logic [31:0] alu, input logic [31:0] data);
    obs_t        e;
    logic [31:0] w, rdat, asum;
    logic [17:0] a;
    logic        rdop;
    int          b;
    w    = (alu - 32'd1024) >> 2;
    rdop = rd & ~wr;
    rdat = '0;
    if (CACHE && rdop && c_vld && c_tag == w) begin
      e.frz = 1'b0; e.we_n = 1'b1; e.addr = '0; e.dq = 16'hffff; e.res = c_dat;
      exp_q.push_back(e);
      exp_res = c_dat;
    end else begin
      for (int c = 0; c < NCYC; c++) begin
        b      = c / (WS + 1);
        asum   = w * 32'd2 + 32'(b);
        a      = asum[17:0];
        e.frz  = 1'b1;
        e.addr = a;
        e.res  = exp_res;
        if (wr) begin
          e.we_n = ((c % (WS + 1)) == WS);
          e.dq   = data[b*16 +: 16];
          ref_mem[a[7:0]] = e.dq;
        end else begin
          e.we_n = 1'b1;
          e.dq   = ((c % (WS + 1)) == WS) ? ref_mem[a[7:0]] : 16'hffff;
          rdat[b*16 +: 16] = ref_mem[a[7:0]];
        end
        exp_q.push_back(e);
      end
      if (rdop) begin
        exp_res = rdat;
        if (CACHE) begin c_vld = 1'b1; c_tag = w; c_dat = rdat; end
      end else if (CACHE && c_vld && c_tag == w) begin
        c_dat = data;
      end
      e.frz = 1'b0; e.we_n = 1'b1; e.addr = '0; e.dq = 16'hffff; e.res = exp_res;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_req(input logic rd, input logic wr, input logic [31:0] alu, input logic [31:0] data);
    obs_t o;
    bit   done;
    done = 1'b0;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; ALU_result = alu; reg2 = data;
    for (int c = 0; c < NCYC + 4 && !done; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      tb_drv = rd & ~wr & ((c % (WS + 1)) == WS);
      @(negedge clk);
      o.frz = freeze; o.we_n = SRAM_WE_N; o.addr = SRAM_ADDR; o.dq = SRAM_DQ; o.res = mem_result;
      obs_q.push_back(o);
      if (freeze === 1'b0) done = 1'b1;
    end
    tb_drv = 1'b0;
  endtask

  task automatic bus_idle();
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_read = 1'b1; mem_write = 1'b0; ALU_result = 32'd1028;
    pcIn = 32'h0000_1234; wb_en = 1'b1; dest = 5'd9; reg2 = 32'h0;
    repeat (2) @(negedge clk);
    checks++; if (freeze !== 1'b0) begin failures++; $display("FAIL reset_freeze: actual %b required 0", freeze); end
    checks++; if (SRAM_WE_N !== 1'b1) begin failures++; $display("FAIL reset_we_n: actual %b required 1", SRAM_WE_N); end
    checks++; if (SRAM_ADDR !== 18'h0) begin failures++; $display("FAIL reset_addr: actual %h required 0", SRAM_ADDR); end
    checks++; if (SRAM_DQ !== 16'hffff) begin failures++; $display("FAIL reset_dq_released: actual %h required ffff", SRAM_DQ); end
    checks++; if (mem_result !== 32'h0) begin failures++; $display("FAIL reset_mem_result: actual %h required 0", mem_result); end
    checks++;
    if ({pcOut, ALU_result_out, wb_en_out, mem_read_out, dest_out} !== {32'h1234, 32'd1028, 1'b1, 1'b1, 5'd9}) begin
      failures++;
      $display("FAIL passthrough: actual %h/%h/%b/%b/%h required 00001234/00000404/1/1/09", pcOut, ALU_result_out, wb_en_out, mem_read_out, dest_out);
    end
    mem_read = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    checks++; if (freeze !== 1'b0) begin failures++; $display("FAIL post_reset_freeze: actual %b required 0", freeze); end
  endtask

  task automatic test_write_read();
    obs_t e, o;
    expect_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    expect_access(1'b1, 1'b0, 32'd1028, 32'h0);
    drive_req(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF); bus_idle();
    drive_req(1'b1, 1'b0, 32'd1028, 32'h0);        bus_idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL write_read: cycle missing, required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL write_read: frz/we_n/addr/dq/res actual %b/%b/%h/%h/%h required %b/%b/%h/%h/%h", o.frz, o.we_n, o.addr, o.dq, o.res, e.frz, e.we_n, e.addr, e.dq, e.res); end
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL write_read_len: actual %0d extra cycles required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_rw_both();
    obs_t e, o;
    expect_access(1'b1, 1'b1, 32'd1032, 32'h12345678);
    expect_access(1'b1, 1'b0, 32'd1032, 32'h0);
    drive_req(1'b1, 1'b1, 32'd1032, 32'h12345678); bus_idle();
    drive_req(1'b1, 1'b0, 32'd1032, 32'h0);        bus_idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL rw_both: cycle missing, required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL rw_both: frz/we_n/addr/dq/res actual %b/%b/%h/%h/%h required %b/%b/%h/%h/%h", o.frz, o.we_n, o.addr, o.dq, o.res, e.frz, e.we_n, e.addr, e.dq, e.res); end
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL rw_both_len: actual %0d extra cycles required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    mem_write = 1'b1; mem_read = 1'b0; ALU_result = 32'd1036; reg2 = 32'hA5A55A5A;
    repeat (2) begin @(negedge clk); @(posedge clk); #1; end
    @(negedge clk);
    checks++; if ({SRAM_WE_N, SRAM_ADDR} !== {1'b0, 18'd7}) begin failures++; $display("FAIL mid_beat1: we_n/addr actual %b/%h required 0/00007", SRAM_WE_N, SRAM_ADDR); end
    #1 rst = 1'b0;
    #1;
    exp_res = '0; c_vld = 1'b0;
    checks++; if (freeze !== 1'b0) begin failures++; $display("FAIL mid_reset_freeze: actual %b required 0", freeze); end
    checks++; if ({SRAM_WE_N, SRAM_ADDR} !== {1'b1, 18'h0}) begin failures++; $display("FAIL mid_reset_bus: we_n/addr actual %b/%h required 1/00000", SRAM_WE_N, SRAM_ADDR); end
    checks++; if (SRAM_DQ !== 16'hffff) begin failures++; $display("FAIL mid_reset_dq: actual %h required ffff", SRAM_DQ); end
    checks++; if (mem_result !== 32'h0) begin failures++; $display("FAIL mid_reset_result: actual %h required 0", mem_result); end
    mem_write = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    checks++; if ({freeze, SRAM_WE_N, SRAM_ADDR} !== {1'b0, 1'b1, 18'h0}) begin failures++; $display("FAIL mid_release: frz/we_n/addr actual %b/%b/%h required 0/1/00000", freeze, SRAM_WE_N, SRAM_ADDR); end
  endtask

  task automatic test_wrap();
    obs_t e, o;
    expect_access(1'b0, 1'b1, 32'd1024 + 32'd4 * 32'd131072, 32'h0BADF00D);
    expect_access(1'b1, 1'b0, 32'd1024, 32'h0);
    drive_req(1'b0, 1'b1, 32'd1024 + 32'd4 * 32'd131072, 32'h0BADF00D); bus_idle();
    drive_req(1'b1, 1'b0, 32'd1024, 32'h0);                             bus_idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL wrap: cycle missing, required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL wrap: frz/we_n/addr/dq/res actual %b/%b/%h/%h/%h required %b/%b/%h/%h/%h", o.frz, o.we_n, o.addr, o.dq, o.res, e.frz, e.we_n, e.addr, e.dq, e.res); end
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL wrap_len: actual %0d extra cycles required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    expect_access(1'b0, 1'b1, 32'd1040, 32'h13579BDF);
    expect_access(1'b1, 1'b0, 32'd1040, 32'h0);
    drive_req(1'b0, 1'b1, 32'd1040, 32'h13579BDF);
    drive_req(1'b1, 1'b0, 32'd1040, 32'h0);
    bus_idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL back_to_back: cycle missing, required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL back_to_back: frz/we_n/addr/dq/res actual %b/%b/%h/%h/%h required %b/%b/%h/%h/%h", o.frz, o.we_n, o.addr, o.dq, o.res, e.frz, e.we_n, e.addr, e.dq, e.res); end
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL back_to_back_len: actual %0d extra cycles required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reread();
    obs_t e, o;
    expect_access(1'b1, 1'b0, 32'd1028, 32'h0);
    expect_access(1'b1, 1'b0, 32'd1028, 32'h0);
    expect_access(1'b0, 1'b1, 32'd1028, 32'hCAFEF00D);
    expect_access(1'b1, 1'b0, 32'd1028, 32'h0);
    drive_req(1'b1, 1'b0, 32'd1028, 32'h0);        bus_idle();
    drive_req(1'b1, 1'b0, 32'd1028, 32'h0);        bus_idle();
    drive_req(1'b0, 1'b1, 32'd1028, 32'hCAFEF00D); bus_idle();
    drive_req(1'b1, 1'b0, 32'd1028, 32'h0);        bus_idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL reread: cycle missing, required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL reread: frz/we_n/addr/dq/res actual %b/%b/%h/%h/%h required %b/%b/%h/%h/%h", o.frz, o.we_n, o.addr, o.dq, o.res, e.frz, e.we_n, e.addr, e.dq, e.res); end
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL reread_len: actual %0d extra cycles required 0", obs_q.size()); obs_q.delete(); end
  endtask

  initial begin
    tb_drv = 1'b0; exp_res = '0; c_vld = 1'b0; c_tag = '0; c_dat = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
    test_reset();
    test_write_read();
    test_rw_both();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    test_reread();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end
endmodule
